// File: rtl/time_set_cmd_parser_pkg.sv
// Shared definitions for the set-time command parser: ASCII codes, field limits, parser states.
// Kept in a package so the planned time-report transmitter can reuse the same constants.
package time_set_cmd_parser_pkg;

    localparam logic [7:0] AsciiT     = 8'h54;
    localparam logic [7:0] AsciiColon = 8'h3A;
    localparam logic [7:0] AsciiCr    = 8'h0D;
    localparam logic [7:0] AsciiZero  = 8'h30;
    localparam logic [7:0] AsciiK     = 8'h4B;
    localparam logic [7:0] AsciiE     = 8'h45;

    localparam int unsigned MaxHour = 23;
    localparam int unsigned MaxMin  = 59;
    localparam int unsigned MaxSec  = 59;

    typedef enum logic [3:0] {
        StIdle,
        StH1,
        StH0,
        StC1,
        StM1,
        StM0,
        StC2,
        StS1,
        StS0,
        StTerm
    } parse_state_e;

endpackage

// File: rtl/time_set_cmd_parser_if.sv
// Byte-stream link between the UART and the command parser: RX strobe in, ack byte out.
interface time_set_cmd_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // UART side
    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid
    );

    // Parser side
    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/time_set_cmd_parser_cmd_gap_timer.sv
// Inter-byte gap timer: counts while enabled, clears on request, pulses expire on the cycle the
// count would reach TIMEOUT_CYC.
module time_set_cmd_parser_cmd_gap_timer #(
    parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] count_q;

    // A clear in the same cycle suppresses expiry, so a byte arriving on time always wins.
    assign expire = enable && !clear && (count_q == CntW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset || clear || expire) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + CntW'(1);
        end
    end

endmodule

// File: rtl/time_set_cmd_parser.sv
// Parses "Thh:mm:ss<CR>" from the UART, pulses reconfig_en with the new time on success and
// returns a one-byte ack ('K' / 'E').
module time_set_cmd_parser
    import time_set_cmd_parser_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TIMEOUT_MS = 100
) (
    input  logic                        clk,
    input  logic                        reset,
    time_set_cmd_parser_if.slave        uart,
    output logic                        reconfig_en,
    output logic [4:0]                  set_hour,
    output logic [5:0]                  set_min,
    output logic [5:0]                  set_sec,
    output logic                        cmd_err
);
    localparam int unsigned TimeoutCyc = CLK_HZ / 1000 * TIMEOUT_MS;

    function automatic logic digit_ok(logic [7:0] b, logic [3:0] max_d);
        return (b >= AsciiZero) && (b <= AsciiZero + 8'(max_d));
    endfunction

    function automatic logic [3:0] digit_val(logic [7:0] b);
        return 4'(b - AsciiZero);
    endfunction

    parse_state_e state_q;
    logic [3:0]   tens_q;
    logic [4:0]   hour_q;
    logic [5:0]   min_q;
    logic [5:0]   sec_q;
    logic [7:0]   tx_data_q;
    logic         tx_valid_q;

    logic         byte_ok;
    logic         expire;
    logic         ack_req;
    logic [7:0]   ack_byte;
    logic [3:0]   digit;
    logic [6:0]   field_val;

    assign digit     = digit_val(uart.rx_data);
    assign field_val = 7'(tens_q) * 7'd10 + 7'(digit);

    always_comb begin
        byte_ok = 1'b0;
        case (state_q)
            StH1:       byte_ok = digit_ok(uart.rx_data, 4'(MaxHour / 10));
            // Hours 20..23: the units digit limit depends on the tens digit already taken.
            StH0:       byte_ok = digit_ok(uart.rx_data, (tens_q == 4'(MaxHour / 10)) ?
                                                         4'(MaxHour % 10) : 4'd9);
            StC1, StC2: byte_ok = (uart.rx_data == AsciiColon);
            StM1:       byte_ok = digit_ok(uart.rx_data, 4'(MaxMin / 10));
            StS1:       byte_ok = digit_ok(uart.rx_data, 4'(MaxSec / 10));
            StM0, StS0: byte_ok = digit_ok(uart.rx_data, 4'd9);
            StTerm:     byte_ok = (uart.rx_data == AsciiCr);
            default:    byte_ok = (uart.rx_data == AsciiT);
        endcase
    end

    always_comb begin
        ack_req  = 1'b0;
        ack_byte = AsciiE;
        if (uart.rx_valid) begin
            if (state_q != StIdle) begin
                if (!byte_ok) begin
                    ack_req = 1'b1;
                end else if (state_q == StTerm) begin
                    ack_req  = 1'b1;
                    ack_byte = AsciiK;
                end
            end
        end else if (expire) begin
            ack_req = 1'b1;
        end
    end

    time_set_cmd_parser_cmd_gap_timer #(
        .TIMEOUT_CYC (TimeoutCyc)
    ) u_gap_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (uart.rx_valid || (state_q == StIdle)),
        .enable (state_q != StIdle),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            tens_q      <= '0;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            reconfig_en <= 1'b0;
            cmd_err     <= 1'b0;
            set_hour    <= '0;
            set_min     <= '0;
            set_sec     <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
        end else begin
            reconfig_en <= 1'b0;
            cmd_err     <= 1'b0;

            if (uart.rx_valid) begin
                if (byte_ok) begin
                    case (state_q)
                        StIdle: state_q <= StH1;
                        StH1: begin
                            tens_q  <= digit;
                            state_q <= StH0;
                        end
                        StH0: begin
                            hour_q  <= 5'(field_val);
                            state_q <= StC1;
                        end
                        StC1: state_q <= StM1;
                        StM1: begin
                            tens_q  <= digit;
                            state_q <= StM0;
                        end
                        StM0: begin
                            min_q   <= 6'(field_val);
                            state_q <= StC2;
                        end
                        StC2: state_q <= StS1;
                        StS1: begin
                            tens_q  <= digit;
                            state_q <= StS0;
                        end
                        StS0: begin
                            sec_q   <= 6'(field_val);
                            state_q <= StTerm;
                        end
                        StTerm: begin
                            reconfig_en <= 1'b1;
                            set_hour    <= hour_q;
                            set_min     <= min_q;
                            set_sec     <= sec_q;
                            state_q     <= StIdle;
                        end
                        default: state_q <= StIdle;
                    endcase
                end else if (state_q != StIdle) begin
                    cmd_err <= 1'b1;
                    state_q <= (uart.rx_data == AsciiT) ? StH1 : StIdle;
                end
            end else if (expire) begin
                cmd_err <= 1'b1;
                state_q <= StIdle;
            end

            // A pending ack is never overwritten; a new one arriving meanwhile is dropped.
            if (tx_valid_q) begin
                if (uart.tx_ready) begin
                    tx_valid_q <= 1'b0;
                end
            end else if (ack_req) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= ack_byte;
            end
        end
    end

    assign uart.tx_data  = tx_data_q;
    assign uart.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_time_set_cmd_parser.sv
// Bench for time_set_cmd_parser: directed vector table, hand sequences and random commands,
// all checked cycle by cycle against a command-string reference model.
module tb_time_set_cmd_parser;
    localparam int unsigned CLK_HZ     = 50_000;
    localparam int unsigned TIMEOUT_MS = 1;
    localparam int          TC         = CLK_HZ / 1000 * TIMEOUT_MS;

    logic       clk;
    logic       reset;
    logic       reconfig_en;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       cmd_err;

    time_set_cmd_parser_if bus ();

    time_set_cmd_parser #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_MS (TIMEOUT_MS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .uart        (bus),
        .reconfig_en (reconfig_en),
        .set_hour    (set_hour),
        .set_min     (set_min),
        .set_sec     (set_sec),
        .cmd_err     (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: the command is tracked as the list of bytes accepted since 'T'.
    logic [7:0] cmd_q[$];
    int         gap;
    logic       m_pulse, m_err, m_txv;
    logic [7:0] m_txd;
    int         m_h, m_m, m_s;

    function automatic bit pos_ok(int pos, logic [7:0] b, logic [7:0] prev);
        int d;
        int t;
        d = int'(b) - 48;
        t = int'(prev) - 48;
        case (pos)
            3, 6:    return b == 8'h3A;
            9:       return b == 8'h0D;
            1:       return d >= 0 && d <= 9 && d * 10 <= 23;
            2:       return d >= 0 && d <= 9 && t * 10 + d <= 23;
            4, 7:    return d >= 0 && d <= 9 && d * 10 <= 59;
            5, 8:    return d >= 0 && d <= 9 && t * 10 + d <= 59;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int field(int i);
        return (int'(cmd_q[i]) - 48) * 10 + (int'(cmd_q[i+1]) - 48);
    endfunction

    task automatic model_reset();
        cmd_q.delete();
        gap = 0;
        m_pulse = 0; m_err = 0; m_txv = 0; m_txd = 8'h00;
        m_h = 0; m_m = 0; m_s = 0;
    endtask

    task automatic model_step(input logic rv, input logic [7:0] rd, input logic rdy);
        int ack;
        ack = -1;
        m_pulse = 0;
        m_err = 0;
        if (rv) begin
            gap = 0;
            if (cmd_q.size() == 0) begin
                if (rd == 8'h54) cmd_q.push_back(rd);
            end else if (pos_ok(cmd_q.size(), rd, cmd_q[cmd_q.size()-1])) begin
                cmd_q.push_back(rd);
                if (cmd_q.size() == 10) begin
                    m_pulse = 1;
                    m_h = field(1);
                    m_m = field(4);
                    m_s = field(7);
                    ack = 8'h4B;
                    cmd_q.delete();
                end
            end else begin
                m_err = 1;
                ack = 8'h45;
                cmd_q.delete();
                if (rd == 8'h54) cmd_q.push_back(rd);
            end
        end else if (cmd_q.size() > 0) begin
            gap++;
            if (gap >= TC) begin
                m_err = 1;
                ack = 8'h45;
                cmd_q.delete();
                gap = 0;
            end
        end
        if (m_txv) begin
            if (rdy) m_txv = 0;
        end else if (ack >= 0) begin
            m_txv = 1;
            m_txd = 8'(ack);
        end
    endtask

    // Observation counters used by the directed checks.
    int         pulses_seen, errs_seen;
    logic [7:0] first_ack;
    logic       prev_txv;

    task automatic clr_obs();
        pulses_seen = 0;
        errs_seen = 0;
        first_ack = 8'h00;
    endtask

    task automatic cycle(input logic rst, input logic rv, input logic [7:0] rd, input logic rdy);
        reset = rst;
        bus.rx_valid = rv;
        bus.rx_data = rd;
        bus.tx_ready = rdy;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(rv, rd, rdy);
        #1;
        check("reconfig_en", int'(reconfig_en), int'(m_pulse));
        check("cmd_err", int'(cmd_err), int'(m_err));
        check("set_hour", int'(set_hour), m_h);
        check("set_min", int'(set_min), m_m);
        check("set_sec", int'(set_sec), m_s);
        check("tx_valid", int'(bus.tx_valid), int'(m_txv));
        check("tx_data", int'(bus.tx_data), int'(m_txd));
        pulses_seen += int'(reconfig_en);
        errs_seen += int'(cmd_err);
        if (bus.tx_valid && !prev_txv && first_ack == 8'h00) first_ack = bus.tx_data;
        prev_txv = bus.tx_valid;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, rdy);
    endtask

    task automatic send(input string s, input logic cr, input int g, input logic rdy);
        for (int i = 0; i < s.len(); i++) begin
            cycle(1'b0, 1'b1, s[i], rdy);
            idle(g, rdy);
        end
        if (cr) begin
            cycle(1'b0, 1'b1, 8'h0D, rdy);
            idle(g, rdy);
        end
    endtask

    typedef struct {
        string      cmd;
        bit         cr;
        int         gap;
        bit         rdy;
        int         pulses;
        int         errs;
        logic [7:0] ack;
        int         h, m, s;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] c[10];
    int         h, m, s, g;
    logic       rdy;

    initial begin
        n_cmp = 0;
        n_fail = 0;
        prev_txv = 1'b0;
        model_reset();
        clr_obs();

        vecs[0] = '{"T12:34:56", 1'b1, 10, 1'b1, 1, 0, 8'h4B, 12, 34, 56};
        vecs[1] = '{"T24:00:00", 1'b1, 0, 1'b1, 0, 1, 8'h45, 12, 34, 56};
        vecs[2] = '{"T0T23:59:59", 1'b1, 1, 1'b0, 1, 1, 8'h45, 23, 59, 59};
        vecs[3] = '{"T00:00:00", 1'b1, 0, 1'b1, 1, 0, 8'h4B, 0, 0, 0};
        vecs[4] = '{"T19:5a", 1'b0, 2, 1'b1, 0, 1, 8'h45, 0, 0, 0};
        vecs[5] = '{"T23:60", 1'b0, 0, 1'b1, 0, 1, 8'h45, 0, 0, 0};
        vecs[6] = '{"xyz:12", 1'b1, 0, 1'b1, 0, 0, 8'h00, 0, 0, 0};

        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        check("reset_tx_valid", int'(bus.tx_valid), 0);
        check("reset_set_hour", int'(set_hour), 0);

        for (int i = 0; i < 7; i++) begin
            clr_obs();
            send(vecs[i].cmd, vecs[i].cr, vecs[i].gap, vecs[i].rdy);
            if (!vecs[i].rdy) begin
                check("held_ack_valid", int'(bus.tx_valid), 1);
                check("held_ack_data", int'(bus.tx_data), 8'h45);
            end
            idle(4, 1'b1);
            check("vec_pulses", pulses_seen, vecs[i].pulses);
            check("vec_errs", errs_seen, vecs[i].errs);
            check("vec_ack", int'(first_ack), int'(vecs[i].ack));
            check("vec_hour", int'(set_hour), vecs[i].h);
            check("vec_min", int'(set_min), vecs[i].m);
            check("vec_sec", int'(set_sec), vecs[i].s);
        end

        // Timeout: the error lands on the TC-th idle cycle after the last byte.
        clr_obs();
        send("T01:0", 1'b0, 0, 1'b1);
        idle(TC - 1, 1'b1);
        check("timeout_early", errs_seen, 0);
        idle(1, 1'b1);
        check("timeout_err", int'(cmd_err), 1);
        idle(2, 1'b1);
        check("timeout_ack", int'(first_ack), 8'h45);

        // A byte on the would-be expiry cycle keeps the command alive.
        clr_obs();
        send("T01:0", 1'b0, 0, 1'b1);
        idle(TC - 1, 1'b1);
        send("2:03", 1'b1, 0, 1'b1);
        idle(3, 1'b1);
        check("gap_edge_errs", errs_seen, 0);
        check("gap_edge_pulse", pulses_seen, 1);
        check("gap_edge_min", int'(set_min), 2);

        // Reset mid-command aborts silently.
        clr_obs();
        send("T01:02:0", 1'b0, 0, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        send("3", 1'b1, 0, 1'b1);
        idle(3, 1'b1);
        check("rst_abort_pulse", pulses_seen, 0);
        check("rst_abort_ack", int'(first_ack), 0);
        check("rst_abort_hour", int'(set_hour), 0);
        check("rst_abort_sec", int'(set_sec), 0);

        // Random commands, some corrupted, with random gaps, junk and TX back-pressure.
        for (int n = 0; n < 150; n++) begin
            h = $urandom_range(0, 23);
            m = $urandom_range(0, 59);
            s = $urandom_range(0, 59);
            c[0] = 8'h54;
            c[1] = 8'(48 + h / 10); c[2] = 8'(48 + h % 10); c[3] = 8'h3A;
            c[4] = 8'(48 + m / 10); c[5] = 8'(48 + m % 10); c[6] = 8'h3A;
            c[7] = 8'(48 + s / 10); c[8] = 8'(48 + s % 10); c[9] = 8'h0D;
            if ($urandom_range(0, 3) == 0) c[$urandom_range(1, 9)] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0)
                cycle(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
            for (int i = 0; i < 10; i++) begin
                rdy = ($urandom_range(0, 3) != 0);
                cycle(1'b0, 1'b1, c[i], rdy);
                if ($urandom_range(0, 19) == 0) g = TC - 1 + int'($urandom_range(0, 1));
                else g = int'($urandom_range(0, 2));
                idle(g, ($urandom_range(0, 1) != 0));
            end
        end
        idle(4, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
